// File: rtl/mc_control_fsm.sv
// Multicycle control FSM for the 16-bit datapath: decodes IR opcode into
// datapath enables and mux selects, stretches memory states on MemReady, latches halt.
module mc_control_fsm (
    input  logic       CLK,
    input  logic       nRST,
    input  logic [3:0] Op,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [1:0] MemtoReg,
    output logic [1:0] RegDst,
    output logic [1:0] ALUOp,
    output logic       Halted,
    output logic       Illegal,
    output logic [3:0] State
);

    localparam int unsigned ST_W  = 4;
    localparam int unsigned OP_W  = 4;
    localparam int unsigned SEL_W = 2;

    typedef enum logic [ST_W-1:0] {
        S_RST      = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_WB_R     = 4'd4,
        S_EXEC_I   = 4'd5,
        S_WB_I     = 4'd6,
        S_MEM_ADDR = 4'd7,
        S_MEM_RD   = 4'd8,
        S_MEM_WB   = 4'd9,
        S_MEM_WR   = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_HALT     = 4'd13
    } state_e;

    localparam logic [OP_W-1:0] OP_R    = 4'h0;
    localparam logic [OP_W-1:0] OP_ADDI = 4'h1;
    localparam logic [OP_W-1:0] OP_LW   = 4'h2;
    localparam logic [OP_W-1:0] OP_SW   = 4'h3;
    localparam logic [OP_W-1:0] OP_BEQ  = 4'h4;
    localparam logic [OP_W-1:0] OP_J    = 4'h5;
    localparam logic [OP_W-1:0] OP_HALT = 4'hF;

    localparam logic [SEL_W-1:0] SRCB_REG  = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_TWO  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b10;
    localparam logic [SEL_W-1:0] PCSRC_OUT = 2'b01;
    localparam logic [SEL_W-1:0] PCSRC_JMP = 2'b10;
    localparam logic [SEL_W-1:0] M2R_MDR   = 2'b01;
    localparam logic [SEL_W-1:0] DST_RD    = 2'b01;
    localparam logic [SEL_W-1:0] ALU_SUB   = 2'b01;
    localparam logic [SEL_W-1:0] ALU_FUNCT = 2'b10;

    state_e state_q, state_d;

    // State register; reset forces RST without waiting for a clock edge
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= S_RST;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and Moore decode; FETCH enables and Illegal also look at inputs
    always_comb begin
        state_d     = state_q;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REG;
        PCSrc       = 2'b00;
        MemtoReg    = 2'b00;
        RegDst      = 2'b00;
        ALUOp       = 2'b00;
        Halted      = 1'b0;
        Illegal     = 1'b0;

        case (state_q)
            S_RST: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_TWO;
                if (MemReady) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcB = SRCB_IMM;
                case (Op)
                    OP_R:          state_d = S_EXEC_R;
                    OP_ADDI:       state_d = S_EXEC_I;
                    OP_LW, OP_SW:  state_d = S_MEM_ADDR;
                    OP_BEQ:        state_d = S_BRANCH;
                    OP_J:          state_d = S_JUMP;
                    OP_HALT:       state_d = S_HALT;
                    default: begin
                        Illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_REG;
                ALUOp   = ALU_FUNCT;
                state_d = S_WB_R;
            end
            S_WB_R: begin
                RegWrite = 1'b1;
                RegDst   = DST_RD;
                state_d  = S_FETCH;
            end
            S_EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                state_d = S_WB_I;
            end
            S_WB_I: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                // IR is stable, so anything other than lw/sw here is unreachable
                if (Op == OP_LW) begin
                    state_d = S_MEM_RD;
                end else if (Op == OP_SW) begin
                    state_d = S_MEM_WR;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (MemReady) begin
                    state_d = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = M2R_MDR;
                state_d  = S_FETCH;
            end
            S_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (MemReady) begin
                    state_d = S_FETCH;
                end
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = SRCB_REG;
                ALUOp       = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSrc       = PCSRC_OUT;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                PCWrite = 1'b1;
                PCSrc   = PCSRC_JMP;
                state_d = S_FETCH;
            end
            S_HALT: begin
                Halted = 1'b1;
            end
            default: begin
                state_d = S_RST;
            end
        endcase
    end

    assign State = ST_W'(state_q);

endmodule

// File: tb/tb_mc_control_fsm.sv
// Table-driven, scoreboarded bench for mc_control_fsm: per-cycle expected state
// and control word compared against the DUT away from the rising edge.
module tb_mc_control_fsm;

    logic       CLK;
    logic       nRST;
    logic [3:0] Op;
    logic       MemReady;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc, MemtoReg, RegDst, ALUOp;
    logic       Halted, Illegal;
    logic [3:0] State;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [1:0] mem_to_reg;
        logic [1:0] reg_dst;
        logic [1:0] alu_op;
        logic       halted;
        logic       illegal;
    } ctl_t;

    typedef struct {
        logic [3:0] st;
        ctl_t       c;
    } exp_t;

    typedef struct {
        logic [3:0] op;
        logic       mr;
        logic [3:0] st;
        ctl_t       c;
    } vec_t;

    localparam ctl_t C_ZERO     = '{default: '0};
    localparam ctl_t C_FETCH_W  = '{mem_read: 1'b1, alu_src_b: 2'b01, default: '0};
    localparam ctl_t C_FETCH_R  = '{mem_read: 1'b1, alu_src_b: 2'b01, ir_write: 1'b1,
                                    pc_write: 1'b1, default: '0};
    localparam ctl_t C_DECODE   = '{alu_src_b: 2'b10, default: '0};
    localparam ctl_t C_DEC_ILL  = '{alu_src_b: 2'b10, illegal: 1'b1, default: '0};
    localparam ctl_t C_EXEC_R   = '{alu_src_a: 1'b1, alu_op: 2'b10, default: '0};
    localparam ctl_t C_WB_R     = '{reg_write: 1'b1, reg_dst: 2'b01, default: '0};
    localparam ctl_t C_EXEC_I   = '{alu_src_a: 1'b1, alu_src_b: 2'b10, default: '0};
    localparam ctl_t C_WB_I     = '{reg_write: 1'b1, default: '0};
    localparam ctl_t C_MEM_RD   = '{mem_read: 1'b1, iord: 1'b1, default: '0};
    localparam ctl_t C_MEM_WB   = '{reg_write: 1'b1, mem_to_reg: 2'b01, default: '0};
    localparam ctl_t C_MEM_WR   = '{mem_write: 1'b1, iord: 1'b1, default: '0};
    localparam ctl_t C_BRANCH   = '{alu_src_a: 1'b1, alu_op: 2'b01, pc_write_cond: 1'b1,
                                    pc_src: 2'b01, default: '0};
    localparam ctl_t C_JUMP     = '{pc_write: 1'b1, pc_src: 2'b10, default: '0};
    localparam ctl_t C_HALT     = '{halted: 1'b1, default: '0};

    ctl_t act;
    assign act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA,
                  ALUSrcB, PCSrc, MemtoReg, RegDst, ALUOp, Halted, Illegal};

    exp_t sb[$];
    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    mc_control_fsm dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .Op         (Op),
        .MemReady   (MemReady),
        .PCWrite    (PCWrite),
        .PCWriteCond(PCWriteCond),
        .IorD       (IorD),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .PCSrc      (PCSrc),
        .MemtoReg   (MemtoReg),
        .RegDst     (RegDst),
        .ALUOp      (ALUOp),
        .Halted     (Halted),
        .Illegal    (Illegal),
        .State      (State)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic push_exp(input logic [3:0] st, input ctl_t c);
        exp_t e;
        e.st = st;
        e.c  = c;
        sb.push_back(e);
    endtask

    task automatic pop_check(input string name);
        exp_t e;
        n_vec++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL %s: scoreboard empty, state act=%0d", name, State);
        end else begin
            e = sb.pop_front();
            if (State !== e.st || act !== e.c) begin
                n_bad++;
                $display("FAIL %s: state act=%0d exp=%0d, ctl act=%05h exp=%05h",
                         name, State, e.st, act, e.c);
            end
        end
    endtask

    // One cycle: drive inputs after the falling edge, check mid-phase, advance
    task automatic step(input logic [3:0] op, input logic mr, input logic [3:0] st,
                        input ctl_t c, input string name);
        Op       = op;
        MemReady = mr;
        push_exp(st, c);
        #2;
        pop_check(name);
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic add(input logic [3:0] op, input logic mr, input logic [3:0] st, input ctl_t c);
        vec_t v;
        v.op = op;
        v.mr = mr;
        v.st = st;
        v.c  = c;
        tbl.push_back(v);
    endtask

    initial begin
        nRST     = 1'b0;
        Op       = 4'h0;
        MemReady = 1'b1;

        // reset release, then R-type (Op ignored outside DECODE/MEM_ADDR)
        add(4'h0, 1'b1, 4'd0,  C_ZERO);
        add(4'h0, 1'b1, 4'd1,  C_FETCH_R);
        add(4'h0, 1'b1, 4'd2,  C_DECODE);
        add(4'h5, 1'b1, 4'd3,  C_EXEC_R);
        add(4'h4, 1'b1, 4'd4,  C_WB_R);
        // addi
        add(4'h1, 1'b1, 4'd1,  C_FETCH_R);
        add(4'h1, 1'b1, 4'd2,  C_DECODE);
        add(4'h1, 1'b1, 4'd5,  C_EXEC_I);
        add(4'h1, 1'b1, 4'd6,  C_WB_I);
        // lw with two stall cycles in MEM_RD
        add(4'h2, 1'b1, 4'd1,  C_FETCH_R);
        add(4'h2, 1'b1, 4'd2,  C_DECODE);
        add(4'h2, 1'b1, 4'd7,  C_EXEC_I);
        add(4'h2, 1'b0, 4'd8,  C_MEM_RD);
        add(4'h2, 1'b0, 4'd8,  C_MEM_RD);
        add(4'h2, 1'b1, 4'd8,  C_MEM_RD);
        add(4'h2, 1'b1, 4'd9,  C_MEM_WB);
        // sw behind a three-cycle fetch stall, plus one write stall
        add(4'h3, 1'b0, 4'd1,  C_FETCH_W);
        add(4'h3, 1'b0, 4'd1,  C_FETCH_W);
        add(4'h3, 1'b0, 4'd1,  C_FETCH_W);
        add(4'h3, 1'b1, 4'd1,  C_FETCH_R);
        add(4'h3, 1'b1, 4'd2,  C_DECODE);
        add(4'h3, 1'b1, 4'd7,  C_EXEC_I);
        add(4'h3, 1'b0, 4'd10, C_MEM_WR);
        add(4'h3, 1'b1, 4'd10, C_MEM_WR);
        // beq, j
        add(4'h4, 1'b1, 4'd1,  C_FETCH_R);
        add(4'h4, 1'b1, 4'd2,  C_DECODE);
        add(4'h4, 1'b1, 4'd11, C_BRANCH);
        add(4'h5, 1'b1, 4'd1,  C_FETCH_R);
        add(4'h5, 1'b1, 4'd2,  C_DECODE);
        add(4'h5, 1'b1, 4'd12, C_JUMP);
        // illegal opcodes at both ends of the 6..E range, then halt
        add(4'h7, 1'b1, 4'd1,  C_FETCH_R);
        add(4'h7, 1'b1, 4'd2,  C_DEC_ILL);
        add(4'h6, 1'b1, 4'd1,  C_FETCH_R);
        add(4'h6, 1'b1, 4'd2,  C_DEC_ILL);
        add(4'hE, 1'b1, 4'd1,  C_FETCH_R);
        add(4'hE, 1'b1, 4'd2,  C_DEC_ILL);
        add(4'hF, 1'b1, 4'd1,  C_FETCH_R);
        add(4'hF, 1'b1, 4'd2,  C_DECODE);
        add(4'hF, 1'b1, 4'd13, C_HALT);

        // reset held over an edge gives all-zero outputs
        @(negedge CLK);
        push_exp(4'd0, C_ZERO);
        #2;
        pop_check("reset_hold");
        @(negedge CLK);
        nRST = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].op, tbl[i].mr, tbl[i].st, tbl[i].c, $sformatf("vec%0d", i));
        end

        // halt is sticky regardless of inputs
        for (int k = 0; k < 20; k++) begin
            step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 4'd13, C_HALT,
                 $sformatf("halt_hold%0d", k));
        end

        // asynchronous reset out of HALT, mid low phase
        #2;
        nRST = 1'b0;
        push_exp(4'd0, C_ZERO);
        #1;
        pop_check("async_rst_halt");
        @(negedge CLK);
        nRST = 1'b1;

        // reset aborting a stalled lw read
        step(4'h2, 1'b1, 4'd0, C_ZERO,    "rst2_rst");
        step(4'h2, 1'b1, 4'd1, C_FETCH_R, "rst2_fetch");
        step(4'h2, 1'b1, 4'd2, C_DECODE,  "rst2_decode");
        step(4'h2, 1'b1, 4'd7, C_EXEC_I,  "rst2_addr");
        step(4'h2, 1'b0, 4'd8, C_MEM_RD,  "rst2_rd");
        #2;
        nRST = 1'b0;
        push_exp(4'd0, C_ZERO);
        #1;
        pop_check("async_rst_memrd");
        @(posedge CLK);
        push_exp(4'd0, C_ZERO);
        #1;
        pop_check("rst_held_edge");
        @(negedge CLK);
        nRST = 1'b1;
        step(4'h3, 1'b1, 4'd0, C_ZERO,    "rst3_rst");
        step(4'h3, 1'b1, 4'd1, C_FETCH_R, "rst3_fetch");
        step(4'h3, 1'b1, 4'd2, C_DECODE,  "rst3_decode");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multicycle control state machine for the 16-bit processor datapath. It decodes the 4-bit opcode held in the instruction register and drives every datapath enable and mux select, including the 2-bit `S` inputs of the 3:1 `mux3b1`/multi-bit 3:1 select muxes (ALUSrcB, PCSrc, MemtoReg, RegDst). It sits directly upstream of those muxes and the register, PC and memory write enables. It stretches memory states on a ready handshake and latches a halt.

## Interface
- No parameters; state encoding and opcode map are fixed below.
- `CLK`  in  1  rising-edge clock
- `nRST`  in  1  asynchronous active-low reset
- `Op`  in  4  opcode from IR[15:12]
- `MemReady`  in  1  memory completes access this cycle
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `IRWrite`, `RegWrite`, `ALUSrcA`  out  1 each  datapath controls
- `ALUSrcB`  out  2  00 reg B, 01 constant 2, 10 sign-extended imm, 11 unused
- `PCSrc`  out  2  00 ALU result, 01 ALUOut, 10 jump target
- `MemtoReg`  out  2  00 ALUOut, 01 MDR
- `RegDst`  out  2  00 rt field, 01 rd field
- `ALUOp`  out  2  00 add, 01 sub, 10 funct-decoded
- `Halted`  out  1  high while in HALT
- `Illegal`  out  1  one-cycle pulse on undefined opcode
- `State`  out  4  current state, debug

## Operation
- Opcodes: 0 R-type, 1 addi, 2 lw, 3 sw, 4 beq, 5 j, F halt; 6–E illegal.
- States and encodings: RST=0, FETCH=1, DECODE=2, EXEC_R=3, WB_R=4, EXEC_I=5, WB_I=6, MEM_ADDR=7, MEM_RD=8, MEM_WB=9, MEM_WR=10, BRANCH=11, JUMP=12, HALT=13. 14 and 15 go to RST.
- RST: all outputs 0. Goes to FETCH.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00.
  - IRWrite and PCWrite are asserted only when MemReady=1, and the state then goes to DECODE.
  - Otherwise the state holds, with the other outputs unchanged.
- DECODE: ALUSrcA=0, ALUSrcB=10, ALUOp=00 (branch target precompute).
  - Dispatch: Op 0→EXEC_R; 1→EXEC_I; 2,3→MEM_ADDR; 4→BRANCH; 5→JUMP; F→HALT.
  - Illegal Op: pulse `Illegal`, go to FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10 → WB_R.
- WB_R: RegWrite=1, RegDst=01, MemtoReg=00 → FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=00 → WB_I.
- WB_I: RegWrite=1, RegDst=00, MemtoReg=00 → FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00 → MEM_RD (Op 2) or MEM_WR (Op 3).
- MEM_RD: MemRead=1, IorD=1. Holds until MemReady=1, then → MEM_WB.
- MEM_WB: RegWrite=1, RegDst=00, MemtoReg=01 → FETCH.
- MEM_WR: MemWrite=1, IorD=1. Holds until MemReady=1, then → FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSrc=01 → FETCH.
- JUMP: PCWrite=1, PCSrc=10 → FETCH.
- HALT: `Halted`=1, all other outputs 0. Left only by reset.
- In every state, any output not listed for that state is 0.

## Timing
- State register updates on the rising edge of `CLK`. `nRST` low forces RST immediately, independent of the clock.
- While `nRST` is low, all outputs are 0 and `State`=0.
- Outputs are Moore, decoded from the registered state. Exception: FETCH's `IRWrite`/`PCWrite` are gated combinationally by `MemReady`.
- `Illegal` is a Mealy pulse during DECODE when Op is illegal.
- Op is sampled only in DECODE and MEM_ADDR. IR is stable after FETCH.
- Cycles per instruction with MemReady always 1, counted from FETCH through the last state:
  - R-type 4, addi 4, lw 5, sw 4, beq 3, j 3.
  - Each low-MemReady cycle in FETCH, MEM_RD or MEM_WR adds one cycle.
- Reset asserted mid-instruction: aborts the instruction, no write enable glitches high, restart at RST.
- First FETCH occurs one cycle after `nRST` deasserts.

## Test plan
- Reset and first fetch:
  - Drive `nRST`=0 mid-cycle → all outputs 0 and `State`=0 at once, without a clock edge.
  - Release with MemReady=1 → `State` sequence 0,1,2.
- R-type:
  - Op=0, MemReady=1 → `State` 1,2,3,4,1.
  - In WB_R, RegWrite=1, RegDst=01, MemtoReg=00.
  - PCWrite is high only in FETCH.
- lw with a 2-cycle memory stall:
  - Op=2, MemReady low for 2 cycles in MEM_RD → `State` 1,2,7,8,8,8,9,1.
  - In MEM_WB, MemtoReg=01 and RegWrite=1.
- sw and stalled fetch:
  - MemReady=0 for 3 cycles in FETCH → state holds at 1 with IRWrite=0, then IRWrite=PCWrite=1 in a single cycle.
  - Op=3 → MemWrite=1 in MEM_WR.
  - RegWrite is never asserted.
- beq and j:
  - Op=4 → BRANCH with PCWriteCond=1, PCSrc=01, ALUOp=01.
  - Op=5 → JUMP with PCWrite=1, PCSrc=10.
  - Each takes 3 cycles.
- Illegal opcode and halt:
  - Op=7 → `Illegal` pulses for 1 cycle in DECODE, then FETCH.
  - Op=F → HALT, with `Halted`=1 held for 20 cycles.
  - Only `nRST` low returns the FSM to RST.
